forward: RTL and testbench
==========================

Name: forward

Overview:
- Forward-propagation engine for the 2-3-2 network; it produces the a2_*/a3_* activations that the backward block consumes.
- Serial MAC datapath: one 32x32 multiply per cycle, with a piecewise-linear sigmoid.
- All data is signed Q8.24 two's complement (0x0100_0000 = 1.0).
- start/busy/done handshake; all outputs are registered.

Parameters:
- FRAC, 24, fractional bits of Q8.24; product slice is bits [FRAC+31:FRAC].
- W, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- res  in  1  reset, asynchronous, active-high.
- start  in  1  request a pass; sampled only in IDLE.
- x_1, x_2  in  32 each  network inputs (a1).
- w2_11, w2_21, w2_12, w2_22, w2_13, w2_23  in  32 each  layer-2 weights; w2_jk is input j to hidden k.
- b2_1, b2_2, b2_3  in  32 each  hidden biases.
- w3_11, w3_21, w3_31, w3_12, w3_22, w3_32  in  32 each  layer-3 weights; w3_jk is hidden j to output k.
- b3_1, b3_2  in  32 each  output biases.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse when results are valid.
- a2_1, a2_2, a2_3  out  32 each  hidden activations.
- a3_1, a3_2  out  32 each  output activations.

Behaviour:
- Reset (async, any state): state goes to IDLE. busy=0, done=0. All a2_*/a3_* = 0. Accumulator and scratch registers cleared.
- IDLE: on an edge with start=1, latch all x/w/b inputs, set busy=1 and move to L2. Input changes after this edge do not affect the pass.
- L2 phase (edges E1..E9), for hidden k=1..3:
  - MAC cycle 1: acc = b2_k + w2_1k*x_1.
  - MAC cycle 2: acc += w2_2k*x_2.
  - ACT cycle: h_k = sig(acc).
- L3 phase (edges E10..E17), for output k=1..2:
  - 3 MAC cycles: b3_k + sum over j of w3_jk*h_j.
  - ACT cycle: y_k = sig(acc).
- Completion at E17:
  - a2_1..3 = h_1..3 and a3_1..2 = y_1..2, all updated atomically.
  - busy goes to 0 and done goes to 1; state returns to IDLE.
- Latency: start edge E0 to done-high edge E17 is 17 cycles.
- done falls on the next edge. Outputs hold until the next completion.
- start while busy is ignored and has no queueing.
- start high at the edge where done rises is also ignored (state is still DONE/last ACT). A new pass is accepted from the following edge.
- Multiply: 64-bit signed product, slice [55:24], truncation (floor); no rounding.
- sig(z) in Q8.24, with m = |z| (|0x8000_0000| taken as 0x7FFF_FFFF):
  - m >= 5.0: f = 1.0.
  - 2.375 <= m < 5.0: f = (m>>>5) + 0.84375.
  - 1.0 <= m < 2.375: f = (m>>>3) + 0.625.
  - m < 1.0: f = (m>>>2) + 0.5.
  - sig(z) = f for z >= 0, and 1.0 - f for z < 0.
  - Output range is 0x0000_0000..0x0100_0000.
- Reset asserted mid-pass: the pass is aborted, done is never produced, and outputs are 0.

Optional Feature:
- Macro: FORWARD_SAT_EN.
- Defined:
  - Product slice saturates to 0x7FFF_FFFF / 0x8000_0000 when the 64-bit product exceeds the Q8.24 range.
  - Accumulator add saturates the same way.
- Undefined: plain two's-complement wrap on both (truncate to 32 bits).
- Ports and latency are identical in both builds.

Test Plan:
- All inputs 0, start pulse -> done exactly 17 cycles after the start edge; all a2_*/a3_* = 0x0080_0000; busy high for E1..E17 only.
- x_1=0x0100_0000, w2_11=0x0100_0000, all else 0 -> a2_1=0x00C0_0000, a2_2=a2_3=0x0080_0000, a3_1=a3_2=0x0080_0000.
- Only b3_1=0x0600_0000 and b3_2=0xFA00_0000 nonzero -> a3_1=0x0100_0000, a3_2=0x0000_0000, a2_*=0x0080_0000.
- start re-pulsed at E5 and inputs changed at E3 -> results equal the values from the original latched inputs, single done. Separately, res asserted at E8 -> outputs 0, no done; a new start then completes normally.
- x_1=w2_11=b2_1=0x7F00_0000, others 0:
  - FORWARD_SAT_EN defined -> a2_1=0x0100_0000.
  - Undefined (product wraps to 1.0, acc wraps to 0x8000_0000) -> a2_1=0x0000_0000.
- Back-to-back passes with start held high continuously -> second pass begins at the first edge after done falls; done pulses spaced 18 cycles apart.

Source files
------------

// File: rtl/forward_if.sv
// Handshake and data bundle for the 2-3-2 forward-propagation engine.
// The bench drives it through master; the engine uses slave.
interface forward_if #(
  parameter int W = 32
);
  logic                start;
  logic                busy;
  logic                done;
  logic signed [W-1:0] x_1, x_2;
  logic signed [W-1:0] w2_11, w2_21, w2_12, w2_22, w2_13, w2_23;
  logic signed [W-1:0] b2_1, b2_2, b2_3;
  logic signed [W-1:0] w3_11, w3_21, w3_31, w3_12, w3_22, w3_32;
  logic signed [W-1:0] b3_1, b3_2;
  logic signed [W-1:0] a2_1, a2_2, a2_3;
  logic signed [W-1:0] a3_1, a3_2;

  modport master (
    output start, x_1, x_2,
    output w2_11, w2_21, w2_12, w2_22, w2_13, w2_23, b2_1, b2_2, b2_3,
    output w3_11, w3_21, w3_31, w3_12, w3_22, w3_32, b3_1, b3_2,
    input  busy, done, a2_1, a2_2, a2_3, a3_1, a3_2
  );

  modport slave (
    input  start, x_1, x_2,
    input  w2_11, w2_21, w2_12, w2_22, w2_13, w2_23, b2_1, b2_2, b2_3,
    input  w3_11, w3_21, w3_31, w3_12, w3_22, w3_32, b3_1, b3_2,
    output busy, done, a2_1, a2_2, a2_3, a3_1, a3_2
  );
endinterface

// File: rtl/forward.sv
// Serial-MAC forward pass of a 2-3-2 network in Q8.24 with piecewise-linear sigmoid.
// Define FORWARD_SAT_EN to saturate the product slice and accumulator add instead of wrapping.
module forward #(
  parameter int W    = 32,
  parameter int FRAC = 24
) (
  input  logic     clk,
  input  logic     res,
  forward_if.slave bus
);

  localparam int W2 = 2 * W;

  localparam logic signed [W-1:0] C_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] C_MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] C_ONE  = W'(64'd1 << FRAC);
  localparam logic signed [W-1:0] C_FIVE = W'(64'd5 << FRAC);
  localparam logic signed [W-1:0] C_T2   = W'(64'd19 << (FRAC - 3));
  localparam logic signed [W-1:0] C_K3   = W'(64'd27 << (FRAC - 5));
  localparam logic signed [W-1:0] C_K2   = W'(64'd5 << (FRAC - 3));
  localparam logic signed [W-1:0] C_HALF = W'(64'd1 << (FRAC - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_L2_MAC,
    S_L2_ACT,
    S_L3_MAC,
    S_L3_ACT
  } state_t;

  state_t state_p, state_nx;
  logic [1:0] j_p, k_p;

  logic signed [W-1:0] x_p0  [0:1];
  logic signed [W-1:0] w2_p0 [0:1][0:2];
  logic signed [W-1:0] b2_p0 [0:2];
  logic signed [W-1:0] w3_p0 [0:2][0:1];
  logic signed [W-1:0] b3_p0 [0:1];
  logic signed [W-1:0] acc_p1;
  logic signed [W-1:0] h_p2  [0:2];
  logic signed [W-1:0] y1_p2;
  logic signed [W-1:0] a2_q  [0:2];
  logic signed [W-1:0] a3_q  [0:1];
  logic                busy_q, done_q;

  logic signed [W-1:0]  op_a, op_b, bias;
  logic signed [W2-1:0] prod_full;
  logic signed [W-1:0]  prod_mid, prod_sl, acc_in, acc_sum, sig_out;
  logic [W2-FRAC-W:0]   prod_hi;
  logic                 prod_unused;

`ifdef FORWARD_SAT_EN
  function automatic logic signed [W-1:0] mul_sat(input logic [W2-FRAC-W:0] hi,
                                                  input logic signed [W-1:0] mid);
    if (hi != {(W2-FRAC-W+1){hi[W2-FRAC-W]}})
      return hi[W2-FRAC-W] ? C_MIN : C_MAX;
    return mid;
  endfunction
`endif

  function automatic logic signed [W-1:0] acc_add(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
`ifdef FORWARD_SAT_EN
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1])
      return s[W] ? C_MIN : C_MAX;
    return s[W-1:0];
`else
    return a + b;
`endif
  endfunction

  function automatic logic signed [W-1:0] sigmoid(input logic signed [W-1:0] z);
    logic signed [W-1:0] m, f;
    // |MIN| does not fit, so it is pinned to MAX (already deep in the f = 1.0 segment)
    if (z == C_MIN)   m = C_MAX;
    else if (z[W-1])  m = -z;
    else              m = z;
    if (m >= C_FIVE)      f = C_ONE;
    else if (m >= C_T2)   f = (m >>> 5) + C_K3;
    else if (m >= C_ONE)  f = (m >>> 3) + C_K2;
    else                  f = (m >>> 2) + C_HALF;
    return z[W-1] ? (C_ONE - f) : f;
  endfunction

  always_ff @(posedge clk or posedge res) begin
    if (res) state_p <= S_IDLE;
    else     state_p <= state_nx;
  end

  always_comb begin
    state_nx = state_p;
    case (state_p)
      S_IDLE:   if (bus.start) state_nx = S_L2_MAC;
      S_L2_MAC: if (j_p == 2'd1) state_nx = S_L2_ACT;
      S_L2_ACT: state_nx = (k_p == 2'd2) ? S_L3_MAC : S_L2_MAC;
      S_L3_MAC: if (j_p == 2'd2) state_nx = S_L3_ACT;
      S_L3_ACT: state_nx = (k_p == 2'd1) ? S_IDLE : S_L3_MAC;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      j_p <= '0;
      k_p <= '0;
    end else begin
      case (state_p)
        S_IDLE: begin
          j_p <= '0;
          k_p <= '0;
        end
        S_L2_MAC: j_p <= (j_p == 2'd1) ? 2'd0 : j_p + 2'd1;
        S_L2_ACT: begin
          j_p <= '0;
          k_p <= (k_p == 2'd2) ? 2'd0 : k_p + 2'd1;
        end
        S_L3_MAC: j_p <= (j_p == 2'd2) ? 2'd0 : j_p + 2'd1;
        S_L3_ACT: begin
          j_p <= '0;
          k_p <= k_p + 2'd1;
        end
        default: begin
          j_p <= '0;
          k_p <= '0;
        end
      endcase
    end
  end

  // Stage 0 -> 1: operand select and the single shared multiplier
  always_comb begin
    op_a = '0;
    op_b = '0;
    bias = '0;
    case (state_p)
      S_L2_MAC: begin
        op_a = w2_p0[j_p[0]][k_p];
        op_b = x_p0[j_p[0]];
        bias = b2_p0[k_p];
      end
      S_L3_MAC: begin
        op_a = w3_p0[j_p][k_p[0]];
        op_b = h_p2[j_p];
        bias = b3_p0[k_p[0]];
      end
      default: ;
    endcase
  end

  assign prod_full   = W2'(op_a) * W2'(op_b);
  assign prod_mid    = prod_full[FRAC+W-1:FRAC];
  assign prod_hi     = prod_full[W2-1:FRAC+W-1];
  assign prod_unused = ^{prod_full[FRAC-1:0], prod_hi};

`ifdef FORWARD_SAT_EN
  assign prod_sl = mul_sat(prod_hi, prod_mid);
`else
  assign prod_sl = prod_mid;
`endif

  assign acc_in  = (j_p == 2'd0) ? bias : acc_p1;
  assign acc_sum = acc_add(acc_in, prod_sl);
  assign sig_out = sigmoid(acc_p1);

  // Stage 1 -> 2: accumulate, activate, and publish all results together
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < 2; i++) begin
        x_p0[i]  <= '0;
        b3_p0[i] <= '0;
        a3_q[i]  <= '0;
        for (int k = 0; k < 3; k++) w2_p0[i][k] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        b2_p0[i] <= '0;
        h_p2[i]  <= '0;
        a2_q[i]  <= '0;
        for (int k = 0; k < 2; k++) w3_p0[i][k] <= '0;
      end
      acc_p1 <= '0;
      y1_p2  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nx != S_IDLE);
      done_q <= (state_p == S_L3_ACT) && (k_p == 2'd1);
      case (state_p)
        S_IDLE: if (bus.start) begin
          x_p0[0]     <= bus.x_1;
          x_p0[1]     <= bus.x_2;
          w2_p0[0][0] <= bus.w2_11;
          w2_p0[1][0] <= bus.w2_21;
          w2_p0[0][1] <= bus.w2_12;
          w2_p0[1][1] <= bus.w2_22;
          w2_p0[0][2] <= bus.w2_13;
          w2_p0[1][2] <= bus.w2_23;
          b2_p0[0]    <= bus.b2_1;
          b2_p0[1]    <= bus.b2_2;
          b2_p0[2]    <= bus.b2_3;
          w3_p0[0][0] <= bus.w3_11;
          w3_p0[1][0] <= bus.w3_21;
          w3_p0[2][0] <= bus.w3_31;
          w3_p0[0][1] <= bus.w3_12;
          w3_p0[1][1] <= bus.w3_22;
          w3_p0[2][1] <= bus.w3_32;
          b3_p0[0]    <= bus.b3_1;
          b3_p0[1]    <= bus.b3_2;
        end
        S_L2_MAC, S_L3_MAC: acc_p1 <= acc_sum;
        S_L2_ACT: h_p2[k_p] <= sig_out;
        S_L3_ACT: begin
          if (k_p == 2'd0) begin
            y1_p2 <= sig_out;
          end else begin
            a2_q[0] <= h_p2[0];
            a2_q[1] <= h_p2[1];
            a2_q[2] <= h_p2[2];
            a3_q[0] <= y1_p2;
            a3_q[1] <= sig_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.a2_1 = a2_q[0];
  assign bus.a2_2 = a2_q[1];
  assign bus.a2_3 = a2_q[2];
  assign bus.a3_1 = a3_q[0];
  assign bus.a3_2 = a3_q[1];

endmodule

// File: tb/tb_forward.sv
// Directed-vector bench for the forward engine with hand-computed Q8.24 results.
module tb_forward;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  forward_if f ();

  forward dut (
    .clk (clk),
    .res (res),
    .bus (f)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    f.x_1 = '0;   f.x_2 = '0;
    f.w2_11 = '0; f.w2_21 = '0; f.w2_12 = '0; f.w2_22 = '0; f.w2_13 = '0; f.w2_23 = '0;
    f.b2_1 = '0;  f.b2_2 = '0;  f.b2_3 = '0;
    f.w3_11 = '0; f.w3_21 = '0; f.w3_31 = '0; f.w3_12 = '0; f.w3_22 = '0; f.w3_32 = '0;
    f.b3_1 = '0;  f.b3_2 = '0;
  endtask

  task automatic set_mix();
    clear_inputs();
    f.x_1   = 32'h0100_0000;
    f.x_2   = 32'h0200_0000;
    f.w2_11 = 32'h0100_0000;
    f.b2_2  = 32'h0300_0000;
    f.b2_3  = 32'hFF80_0000;
    f.w2_23 = 32'h0020_0000;
    f.w3_11 = 32'h0100_0000;
    f.w3_21 = 32'h0100_0000;
    f.w3_12 = 32'hFE00_0000;
    f.w3_32 = 32'h0100_0000;
  endtask

  task automatic check_out(input string tag, input logic [31:0] e21, input logic [31:0] e22,
                           input logic [31:0] e23, input logic [31:0] e31, input logic [31:0] e32);
    check({tag, " a2_1"}, f.a2_1, e21);
    check({tag, " a2_2"}, f.a2_2, e22);
    check({tag, " a2_3"}, f.a2_3, e23);
    check({tag, " a3_1"}, f.a3_1, e31);
    check({tag, " a3_2"}, f.a3_2, e32);
  endtask

  task automatic run_pass(input string tag);
    int   cyc;
    int   busy_drop;
    logic b0;
    @(negedge clk);
    f.start = 1'b1;
    @(posedge clk);
    #1 b0 = f.busy;
    @(negedge clk);
    f.start = 1'b0;
    cyc = 0;
    busy_drop = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (f.done) begin
        cyc = c;
        break;
      end
      if (!f.busy) busy_drop++;
    end
    check({tag, " busy_after_start"}, 32'(b0), 32'd1);
    check({tag, " latency"}, cyc, 32'd17);
    check({tag, " busy_gaps"}, busy_drop, 32'd0);
    check({tag, " busy_at_done"}, 32'(f.busy), 32'd0);
    @(posedge clk);
    #1 check({tag, " done_fall"}, 32'(f.done), 32'd0);
  endtask

  initial begin
    int nd, first, t1, t2, idle_seen;
    res = 1'b1;
    f.start = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", 32'(f.busy), 32'd0);
    check("rst done", 32'(f.done), 32'd0);
    check("rst a2_1", f.a2_1, 32'd0);
    check("rst a3_2", f.a3_2, 32'd0);
    res = 1'b0;

    clear_inputs();
    run_pass("zero");
    check_out("zero", 32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000);

    clear_inputs();
    f.x_1 = 32'h0100_0000;
    f.w2_11 = 32'h0100_0000;
    run_pass("x1w11");
    check_out("x1w11", 32'h00C0_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000);

    clear_inputs();
    f.b3_1 = 32'h0600_0000;
    f.b3_2 = 32'hFA00_0000;
    run_pass("b3");
    check_out("b3", 32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0100_0000, 32'h0000_0000);

    set_mix();
    run_pass("mix");
    check_out("mix", 32'h00C0_0000, 32'h00F0_0000, 32'h0070_0000, 32'h00D6_0000, 32'h003E_0000);

    clear_inputs();
    f.x_1 = 32'hFFFF_FFFF;
    f.w2_11 = 32'h0780_0000;
    run_pass("trunc");
    check_out("trunc", 32'h007F_FFFE, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000);

    clear_inputs();
    f.x_1 = 32'h7F00_0000;
    f.w2_11 = 32'h7F00_0000;
    f.b2_1 = 32'h7F00_0000;
    run_pass("ovf");
`ifdef FORWARD_SAT_EN
    check("ovf a2_1", f.a2_1, 32'h0100_0000);
`else
    check("ovf a2_1", f.a2_1, 32'h0000_0000);
`endif
    check("ovf a3_1", f.a3_1, 32'h0080_0000);

    // inputs change at E3 and start re-pulses at E5; the latched pass must be unaffected
    clear_inputs();
    f.x_1 = 32'h0100_0000;
    f.w2_11 = 32'h0100_0000;
    @(negedge clk);
    f.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    f.start = 1'b0;
    nd = 0;
    first = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (f.done) begin
        nd++;
        if (first == 0) first = c;
      end
      if (c == 3) begin
        f.x_1 = 32'h0200_0000;
        f.b3_1 = 32'h0600_0000;
      end
      if (c == 4) f.start = 1'b1;
      if (c == 5) f.start = 1'b0;
    end
    check("busy_start done_count", nd, 32'd1);
    check("busy_start done_cycle", first, 32'd17);
    check_out("busy_start", 32'h00C0_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000);

    // reset mid-pass at E8
    set_mix();
    @(negedge clk);
    f.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    f.start = 1'b0;
    repeat (8) @(posedge clk);
    #2 res = 1'b1;
    @(negedge clk);
    check("abort busy", 32'(f.busy), 32'd0);
    check("abort done", 32'(f.done), 32'd0);
    check("abort a2_1", f.a2_1, 32'd0);
    check("abort a3_1", f.a3_1, 32'd0);
    res = 1'b0;
    nd = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1 if (f.done) nd++;
    end
    check("abort no_done", nd, 32'd0);
    run_pass("after_abort");
    check_out("after_abort", 32'h00C0_0000, 32'h00F0_0000, 32'h0070_0000, 32'h00D6_0000, 32'h003E_0000);

    // start held high: done pulses 18 cycles apart
    clear_inputs();
    f.b3_1 = 32'h0600_0000;
    f.b3_2 = 32'hFA00_0000;
    @(negedge clk);
    f.start = 1'b1;
    @(posedge clk);
    t1 = 0;
    t2 = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (f.done) begin
        if (t1 == 0) t1 = c;
        else if (t2 == 0) t2 = c;
      end
    end
    @(negedge clk);
    f.start = 1'b0;
    check("b2b first_done", t1, 32'd17);
    check("b2b spacing", t2 - t1, 32'd18);
    idle_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (!f.busy) begin
        idle_seen = 1;
        break;
      end
    end
    check("b2b drain", idle_seen, 32'd1);
    check_out("b2b", 32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0100_0000, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
